huffman_code_walker: RTL and testbench

Sequencer that turns the 13-bit Huffman node-info table into per-symbol codewords. It walks each node's parent chain up to the root through a single-port node-table read interface, accumulates branch bits and code length, and hands each finished codeword to the code-emit stage with a valid/ready handshake. It sits between the tree-build node table and the codeword/state output registers.

---
 rtl/huffman_code_walker.sv | 223 ++++++++++++++++++++++
 tb/tb_huffman_code_walker.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_code_walker.sv
// huffman_code_walker
// Walks every symbol's parent chain in the Huffman node-info table up to the
// root. Each step records one branch bit, and the finished codeword is handed
// downstream over a valid/ready handshake.
//
// Optional build macro: HUFF_WALK_LEVEL_CHECK_EN
//   defined   - each node word's level field must step down by exactly one per
//               parent hop, and the root must be level 0. A mismatch raises err
//               and drops the symbol.
//   undefined - the level field is ignored.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | read strobe for node cur, one cycle
// EVAL  | node word on rd_data: record branch / emit / skip symbol
// EMIT  | codeword presented, held until code_ready
// DONE  | one-cycle completion pulse, then IDLE

module huffman_code_walker #(
  parameter int NUM_NODES = 7,
  parameter int MAX_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [3:0]           rd_addr,
  input  logic [12:0]          rd_data,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic [3:0]           code_sym,
  output logic [MAX_DEPTH-1:0] code_bits,
  output logic [3:0]           code_len,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EVAL  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]           LAST_SYM  = 4'(NUM_NODES);
  localparam logic [3:0]           DEPTH_MAX = 4'(MAX_DEPTH);
  localparam logic [MAX_DEPTH-1:0] BIT_ONE   = MAX_DEPTH'(1);

  state_t               state_q, state_nxt;
  logic [3:0]           sym_q, sym_nxt;
  logic [3:0]           cur_q, cur_nxt;
  logic [3:0]           len_q, len_nxt;
  logic [MAX_DEPTH-1:0] bits_q, bits_nxt;
  logic                 err_q, err_nxt;
  logic                 skip;

  // Node word fields
  logic [3:0] rd_lvl;
  logic       rd_branch;
  logic [3:0] rd_par;
  logic [3:0] rd_id;
  logic       is_root;
  logic       parent_bad;
  logic       lvl_bad;

  assign rd_lvl     = rd_data[12:9];
  assign rd_branch  = rd_data[8];
  assign rd_par     = rd_data[7:4];
  assign rd_id      = rd_data[3:0];
  assign is_root    = (rd_id == rd_par);
  assign parent_bad = (rd_par == 4'd0) || (rd_par > LAST_SYM);

`ifdef HUFF_WALK_LEVEL_CHECK_EN
  // Expected level of the next word in the chain. It is one bit wider than the
  // level field so that a hop above level 0 yields a value no 4-bit level can match.
  logic [4:0] lvl_exp_q, lvl_exp_nxt;

  // A word fails the level check if it is not one below the previous hop
  // (first read of a symbol sets the reference), or if it is a root not at 0.
  always_comb begin
    lvl_bad = 1'b0;
    if ((len_q != 4'd0) && ({1'b0, rd_lvl} != lvl_exp_q))
      lvl_bad = 1'b1;
    if (is_root && (rd_lvl != 4'd0))
      lvl_bad = 1'b1;
  end
`else
  logic unused_lvl;

  assign unused_lvl = ^rd_lvl;
  assign lvl_bad    = 1'b0;
`endif

  // State and walk registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      sym_q   <= 4'd0;
      cur_q   <= 4'd0;
      len_q   <= 4'd0;
      bits_q  <= '0;
      err_q   <= 1'b0;
`ifdef HUFF_WALK_LEVEL_CHECK_EN
      lvl_exp_q <= 5'd0;
`endif
    end else begin
      state_q <= state_nxt;
      sym_q   <= sym_nxt;
      cur_q   <= cur_nxt;
      len_q   <= len_nxt;
      bits_q  <= bits_nxt;
      err_q   <= err_nxt;
`ifdef HUFF_WALK_LEVEL_CHECK_EN
      lvl_exp_q <= lvl_exp_nxt;
`endif
    end
  end

  // Next-state, datapath update and outputs
  always_comb begin
    state_nxt  = state_q;
    sym_nxt    = sym_q;
    cur_nxt    = cur_q;
    len_nxt    = len_q;
    bits_nxt   = bits_q;
    err_nxt    = err_q;
`ifdef HUFF_WALK_LEVEL_CHECK_EN
    lvl_exp_nxt = lvl_exp_q;
`endif
    skip       = 1'b0;

    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = 4'd0;
    code_valid = 1'b0;
    code_sym   = 4'd0;
    code_bits  = '0;
    code_len   = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          sym_nxt   = 4'd1;
          cur_nxt   = 4'd1;
          len_nxt   = 4'd0;
          bits_nxt  = '0;
          err_nxt   = 1'b0;
        end
      end

      S_FETCH: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = cur_q;
        state_nxt = S_EVAL;
      end

      S_EVAL: begin
        busy = 1'b1;
        if (lvl_bad || parent_bad) begin
          err_nxt = 1'b1;
          skip    = 1'b1;
        end else if (is_root) begin
          // A symbol that is itself the root has no codeword.
          if (len_q == 4'd0)
            skip = 1'b1;
          else
            state_nxt = S_EMIT;
        end else if (len_q == DEPTH_MAX) begin
          // Chain longer than a codeword can hold: broken table or a loop.
          err_nxt = 1'b1;
          skip    = 1'b1;
        end else begin
          bits_nxt  = bits_q | ({MAX_DEPTH{rd_branch}} & (BIT_ONE << len_q));
          len_nxt   = len_q + 4'd1;
          cur_nxt   = rd_par;
          state_nxt = S_FETCH;
`ifdef HUFF_WALK_LEVEL_CHECK_EN
          lvl_exp_nxt = {1'b0, rd_lvl} - 5'd1;
`endif
        end
      end

      S_EMIT: begin
        busy       = 1'b1;
        code_valid = 1'b1;
        code_sym   = sym_q;
        code_bits  = bits_q;
        code_len   = len_q;
        if (code_ready)
          skip = 1'b1;
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    // Move to the next symbol, or finish after the last one.
    if (skip) begin
      if (sym_q == LAST_SYM) begin
        state_nxt = S_DONE;
      end else begin
        sym_nxt   = sym_q + 4'd1;
        cur_nxt   = sym_q + 4'd1;
        len_nxt   = 4'd0;
        bits_nxt  = '0;
        state_nxt = S_FETCH;
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_huffman_code_walker.sv
// Testbench for huffman_code_walker: a node-table memory model, randomized
// tables and backpressure, and a chain-walking reference model that derives
// the expected codewords straight from the table contents.
// Honours HUFF_WALK_LEVEL_CHECK_EN the same way the design does.

module tb_huffman_code_walker;

  localparam int NN = 7;
  localparam int MD = 8;

  logic          CLK;
  logic          RST;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [12:0]   rd_data;
  logic          code_valid;
  logic          code_ready;
  logic [3:0]    code_sym;
  logic [MD-1:0] code_bits;
  logic [3:0]    code_len;
  logic          err;

  huffman_code_walker #(.NUM_NODES(NN), .MAX_DEPTH(MD)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_sym   (code_sym),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .err        (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [12:0] mem [0:15];

  // Single-port table: word appears the cycle after the strobe, junk otherwise.
  always @(posedge CLK) rd_data <= rd_en ? mem[rd_addr] : 13'($urandom);

  // Protocol monitors: stability under backpressure and no back-to-back reads.
  int b2b_viol  = 0;
  int stab_viol = 0;
  logic          pv_valid = 1'b0, pv_ready = 1'b0, pv_rst = 1'b1, pv_rden = 1'b0;
  logic [3:0]    pv_sym = '0, pv_len = '0;
  logic [MD-1:0] pv_bits = '0;

  always @(negedge CLK) begin
    if (pv_valid && !pv_ready && !pv_rst) begin
      if (!code_valid || code_sym !== pv_sym || code_bits !== pv_bits || code_len !== pv_len)
        stab_viol <= stab_viol + 1;
    end
    if (rd_en && pv_rden && !pv_rst)
      b2b_viol <= b2b_viol + 1;
    pv_valid <= code_valid;
    pv_ready <= code_ready;
    pv_rst   <= RST;
    pv_rden  <= rd_en;
    pv_sym   <= code_sym;
    pv_bits  <= code_bits;
    pv_len   <= code_len;
  end

  // Collected and expected codewords
  logic [3:0]    got_sym[$];
  logic [MD-1:0] got_bits[$];
  logic [3:0]    got_len[$];
  logic [3:0]    exp_sym[$];
  logic [MD-1:0] exp_bits[$];
  logic [3:0]    exp_len[$];
  bit            exp_err;

  int done_cnt, first_valid_iter, hold_seen, busy_viol;
  bit timed_out;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // Reference: follow each symbol's parent chain and apply the walking rules.
  task automatic build_expect();
    int node, depth, prev_lvl, lvl, par, id;
    bit walking, lvl_ok, br;
    logic [MD-1:0] bits;
    logic [12:0] w;
    exp_sym.delete(); exp_bits.delete(); exp_len.delete();
    exp_err = 1'b0;
    for (int s = 1; s <= NN; s++) begin
      node = s; depth = 0; prev_lvl = 0; bits = '0; walking = 1'b1;
      while (walking) begin
        w = mem[node];
        lvl = int'(w[12:9]); br = w[8]; par = int'(w[7:4]); id = int'(w[3:0]);
        lvl_ok = 1'b1;
`ifdef HUFF_WALK_LEVEL_CHECK_EN
        if (depth > 0 && lvl != prev_lvl - 1) lvl_ok = 1'b0;
        if (id == par && lvl != 0) lvl_ok = 1'b0;
`endif
        if (!lvl_ok || par == 0 || par > NN) begin
          exp_err = 1'b1; walking = 1'b0;
        end else if (id == par) begin
          if (depth > 0) begin
            exp_sym.push_back(4'(s)); exp_bits.push_back(bits); exp_len.push_back(4'(depth));
          end
          walking = 1'b0;
        end else if (depth == MD) begin
          exp_err = 1'b1; walking = 1'b0;
        end else begin
          bits[depth] = br; depth++; prev_lvl = lvl; node = par;
        end
      end
    end
  endtask

  task automatic load_balanced();
    for (int a = 0; a < 16; a++) mem[a] = 13'($urandom);
    mem[1] = {4'd0, 1'b0, 4'd1, 4'd1};
    mem[2] = {4'd1, 1'b0, 4'd1, 4'd2};
    mem[3] = {4'd1, 1'b1, 4'd1, 4'd3};
    mem[4] = {4'd2, 1'b0, 4'd2, 4'd4};
    mem[5] = {4'd2, 1'b1, 4'd2, 4'd5};
    mem[6] = {4'd2, 1'b0, 4'd3, 4'd6};
    mem[7] = {4'd2, 1'b1, 4'd3, 4'd7};
  endtask

  task automatic gen_random_table();
    int lv[16];
    int p, idx;
    for (int a = 0; a < 16; a++) begin mem[a] = 13'($urandom); lv[a] = 0; end
    mem[1] = {4'd0, 1'b0, 4'd1, 4'd1};
    for (int i = 2; i <= NN; i++) begin
      p = ($urandom_range(0, 3) == 0) ? i - 1 : int'($urandom_range(1, i - 1));
      lv[i] = lv[p] + 1;
      mem[i] = {4'(lv[i]), 1'($urandom), 4'(p), 4'(i)};
    end
    for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
      idx = int'($urandom_range(1, NN));
      case ($urandom_range(0, 3))
        0: mem[idx][7:4] = 4'd0;
        1: mem[idx][7:4] = 4'($urandom_range(NN + 1, 15));
        2: mem[idx][7:4] = 4'($urandom_range(1, NN));
        default: mem[idx][12:9] = 4'($urandom);
      endcase
    end
  endtask

  // One full walk: start pulse, ready pattern, optional held-off symbol and
  // stray start pulses while busy or in the DONE cycle.
  task automatic run_walk(input int ready_pct, input int hold_sym, input int hold_cycles,
                          input bit extra_start);
    int iter, post, hold_used;
    bit fin;
    got_sym.delete(); got_bits.delete(); got_len.delete();
    done_cnt = 0; first_valid_iter = -1; hold_seen = 0; busy_viol = 0; timed_out = 1'b0;
    iter = 0; post = 0; hold_used = 0; fin = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1;
    code_ready = ($urandom_range(1, 100) <= ready_pct);
    while (!(fin && post >= 4)) begin
      @(posedge CLK); #1;
      iter++;
      start = 1'b0;
      if (extra_start && busy) start = ($urandom_range(0, 3) == 0);
      if (extra_start && done) start = 1'b1;
      if (code_valid && hold_sym != 0 && code_sym == 4'(hold_sym) && hold_used < hold_cycles) begin
        code_ready = 1'b0; hold_used++;
      end else begin
        code_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      @(negedge CLK);
      if (code_valid && first_valid_iter < 0) first_valid_iter = iter;
      if (code_valid && hold_sym != 0 && code_sym == 4'(hold_sym)) hold_seen++;
      if (code_valid && code_ready) begin
        got_sym.push_back(code_sym); got_bits.push_back(code_bits); got_len.push_back(code_len);
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_viol++;
        fin = 1'b1;
      end else if (!fin && !busy) begin
        busy_viol++;
      end else if (fin && busy) begin
        busy_viol++;
      end
      if (fin) post++;
      if (iter >= 4000) begin timed_out = 1'b1; fin = 1'b1; post = 4; end
    end
    start = 1'b0;
    code_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; code_ready = 1'b0;
    for (int a = 0; a < 16; a++) mem[a] = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, rd_en, code_valid, err} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b required 00000", {busy, done, rd_en, code_valid, err}); end
    checks++;
    if ({rd_addr, code_sym, code_len} !== 12'h0)
      begin errors++; $display("FAIL reset_fields: got %h required 000", {rd_addr, code_sym, code_len}); end
    checks++;
    if (code_bits !== '0)
      begin errors++; $display("FAIL reset_bits: got %h required 0", code_bits); end
    RST = 1'b0;
    // start while held idle is not yet issued: nothing may move
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0)
      begin errors++; $display("FAIL idle_quiet: busy=%b rd_en=%b required 0 0", busy, rd_en); end
  endtask

  task automatic test_balanced();
    logic [3:0]    bs[6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0]    bl[6] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [MD-1:0] bb[6] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3};
    load_balanced();
    run_walk(100, 0, 0, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL bal_timeout: got timeout required done"); end
    checks++;
    if (first_valid_iter != 7)
      begin errors++; $display("FAIL bal_latency: got %0d cycles required 7", first_valid_iter); end
    checks++;
    if (got_sym.size() != 6)
      begin errors++; $display("FAIL bal_count: got %0d required 6", got_sym.size()); end
    for (int i = 0; i < 6 && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== bs[i] || got_len[i] !== bl[i] || got_bits[i] !== bb[i]) begin
        errors++;
        $display("FAIL bal_word%0d: got sym%0d len%0d bits %h required sym%0d len%0d bits %h",
                 i, got_sym[i], got_len[i], got_bits[i], bs[i], bl[i], bb[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bal_done: got %0d pulses required 1", done_cnt); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL bal_err: got %b required 0", err); end
    checks++;
    if (busy_viol != 0) begin errors++; $display("FAIL bal_busy: got %0d violations required 0", busy_viol); end
  endtask

  task automatic test_backpressure();
    load_balanced();
    build_expect();
    run_walk(100, 4, 5, 1'b0);
    checks++;
    if (hold_seen != 6)
      begin errors++; $display("FAIL bp_hold: sym4 valid for %0d cycles required 6", hold_seen); end
    checks++;
    if (got_sym.size() != exp_sym.size())
      begin errors++; $display("FAIL bp_count: got %0d required %0d", got_sym.size(), exp_sym.size()); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_len[i] !== exp_len[i] || got_bits[i] !== exp_bits[i])
        begin errors++; $display("FAIL bp_word%0d: got sym%0d len%0d bits %h required sym%0d len%0d bits %h",
                                 i, got_sym[i], got_len[i], got_bits[i], exp_sym[i], exp_len[i], exp_bits[i]); end
    end
    checks++;
    if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_loop();
    logic [3:0]    ls[4] = '{4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0]    ll[4] = '{4'd1, 4'd1, 4'd2, 4'd2};
    logic [MD-1:0] lb[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
    load_balanced();
    mem[2] = {4'd1, 1'b0, 4'd3, 4'd2};
    mem[3] = {4'd1, 1'b1, 4'd2, 4'd3};
    mem[4] = {4'd1, 1'b0, 4'd1, 4'd4};
    mem[5] = {4'd1, 1'b1, 4'd1, 4'd5};
    mem[6] = {4'd2, 1'b0, 4'd4, 4'd6};
    mem[7] = {4'd2, 1'b1, 4'd4, 4'd7};
    run_walk(70, 0, 0, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL loop_err: got %b required 1", err); end
    checks++;
    if (got_sym.size() != 4) begin errors++; $display("FAIL loop_count: got %0d required 4", got_sym.size()); end
    for (int i = 0; i < 4 && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== ls[i] || got_len[i] !== ll[i] || got_bits[i] !== lb[i])
        begin errors++; $display("FAIL loop_word%0d: got sym%0d len%0d bits %h required sym%0d len%0d bits %h",
                                 i, got_sym[i], got_len[i], got_bits[i], ls[i], ll[i], lb[i]); end
    end
    checks++;
    if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL loop_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_rst_mid();
    bit seen;
    load_balanced();
    code_ready = 1'b1;
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (rd_en && rd_addr == 4'd5) seen = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_reach: got no read of node 5 required one"); end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({busy, done, rd_en, rd_addr, code_valid, code_sym, code_bits, code_len, err} !== '0)
      begin errors++; $display("FAIL rst_outputs: got %h required 0",
                               {busy, done, rd_en, rd_addr, code_valid, code_sym, code_bits, code_len, err}); end
    RST = 1'b0;
    code_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0)
      begin errors++; $display("FAIL rst_idle: busy=%b rd_en=%b required 0 0", busy, rd_en); end
    build_expect();
    run_walk(100, 0, 0, 1'b0);
    checks++;
    if (got_sym.size() != exp_sym.size() || done_cnt != 1)
      begin errors++; $display("FAIL rst_rerun: got %0d words %0d done required %0d words 1 done",
                               got_sym.size(), done_cnt, exp_sym.size()); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_len[i] !== exp_len[i] || got_bits[i] !== exp_bits[i])
        begin errors++; $display("FAIL rst_word%0d: got sym%0d len%0d bits %h required sym%0d len%0d bits %h",
                                 i, got_sym[i], got_len[i], got_bits[i], exp_sym[i], exp_len[i], exp_bits[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    load_balanced();
    build_expect();
    run_walk(60, 0, 0, 1'b1);
    checks++;
    if (got_sym.size() != exp_sym.size())
      begin errors++; $display("FAIL sb_count: got %0d required %0d", got_sym.size(), exp_sym.size()); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_len[i] !== exp_len[i] || got_bits[i] !== exp_bits[i])
        begin errors++; $display("FAIL sb_word%0d: got sym%0d len%0d bits %h required sym%0d len%0d bits %h",
                                 i, got_sym[i], got_len[i], got_bits[i], exp_sym[i], exp_len[i], exp_bits[i]); end
    end
    checks++;
    if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL sb_done: got %0d pulses required 1", done_cnt); end
    checks++;
    if (busy_viol != 0) begin errors++; $display("FAIL sb_busy: got %0d violations required 0", busy_viol); end
  endtask

  task automatic test_level();
    int want_n;
    bit want_err;
    load_balanced();
    mem[4][12:9] = 4'd3;
`ifdef HUFF_WALK_LEVEL_CHECK_EN
    want_n = 5; want_err = 1'b1;
`else
    want_n = 6; want_err = 1'b0;
`endif
    build_expect();
    run_walk(80, 0, 0, 1'b0);
    checks++;
    if (err !== want_err) begin errors++; $display("FAIL lvl_err: got %b required %b", err, want_err); end
    checks++;
    if (got_sym.size() != want_n) begin errors++; $display("FAIL lvl_count: got %0d required %0d", got_sym.size(), want_n); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_len[i] !== exp_len[i] || got_bits[i] !== exp_bits[i])
        begin errors++; $display("FAIL lvl_word%0d: got sym%0d len%0d bits %h required sym%0d len%0d bits %h",
                                 i, got_sym[i], got_len[i], got_bits[i], exp_sym[i], exp_len[i], exp_bits[i]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      gen_random_table();
      build_expect();
      run_walk(int'($urandom_range(30, 100)), 0, 0, 1'($urandom));
      checks++;
      if (timed_out || done_cnt != 1)
        begin errors++; $display("FAIL rnd%0d_done: got %0d pulses timeout=%0b required 1", t, done_cnt, timed_out); end
      checks++;
      if (err !== exp_err) begin errors++; $display("FAIL rnd%0d_err: got %b required %b", t, err, exp_err); end
      checks++;
      if (got_sym.size() != exp_sym.size())
        begin errors++; $display("FAIL rnd%0d_count: got %0d required %0d", t, got_sym.size(), exp_sym.size()); end
      for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
        checks++;
        if (got_sym[i] !== exp_sym[i] || got_len[i] !== exp_len[i] || got_bits[i] !== exp_bits[i])
          begin errors++; $display("FAIL rnd%0d_word%0d: got sym%0d len%0d bits %h required sym%0d len%0d bits %h",
                                   t, i, got_sym[i], got_len[i], got_bits[i], exp_sym[i], exp_len[i], exp_bits[i]); end
      end
      checks++;
      if (busy_viol != 0) begin errors++; $display("FAIL rnd%0d_busy: got %0d violations required 0", t, busy_viol); end
    end
  endtask

  task automatic test_protocol();
    @(negedge CLK);
    checks++;
    if (b2b_viol != 0) begin errors++; $display("FAIL proto_b2b: got %0d back-to-back reads required 0", b2b_viol); end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL proto_stable: got %0d unstable cycles required 0", stab_viol); end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; code_ready = 1'b0;
    test_reset();
    test_balanced();
    test_backpressure();
    test_loop();
    test_rst_mid();
    test_start_while_busy();
    test_level();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
